// File: rtl/vga_sync_tracker.sv
// Receive-side VGA sync tracker: rebuilds pixel/line counters from hsync/vsync,
// verifies line, pulse-width and frame timing, and reports lock with active-area coordinates.
module vga_sync_tracker #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 514,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] h_pos,
    output logic [9:0] v_pos,
    output logic       locked,
    output logic       de,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frame_start,
    output logic       sync_err
);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_LOW    = 10'(H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA_START = 10'(H_ACT_START);
    localparam logic [9:0] HA_END   = 10'(H_ACT_END);
    localparam logic [9:0] VA_START = 10'(V_ACT_START);
    localparam logic [9:0] VA_END   = 10'(V_ACT_END);
    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t     state_reg, state_next;
    logic [2:0] hs_reg, vs_reg;
    logic [9:0] h_reg, h_next, v_reg, v_next, x_reg, x_next, y_diff;
    logic [8:0] y_reg, y_next;
    logic [3:0] good_reg, good_next;
    logic       v_pend_reg, v_pend_next, frame_bad_reg, frame_bad_next;
    logic       first_line_reg, first_line_next, first_frame_reg, first_frame_next;
    logic       de_reg, de_next, fs_reg, err_reg;
    logic       h_fall, h_rise, v_fall, align, line_err, width_err, frame_err;
    logic       chk_err, timeout, frame_ok, enter_search;

    // Two sync stages plus one history stage per input: [1] is current, [2] is previous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_reg <= '1;
            vs_reg <= '1;
        end else if (pix_ce) begin
            hs_reg <= {hs_reg[1:0], hsync_in};
            vs_reg <= {vs_reg[1:0], vsync_in};
        end
    end

    assign h_fall = hs_reg[2] & ~hs_reg[1];
    assign h_rise = ~hs_reg[2] & hs_reg[1];
    assign v_fall = vs_reg[2] & ~vs_reg[1];
    assign align  = h_fall & (v_pend_reg | v_fall);

    // The rise lands on the first high pixel, whose index must equal the pulse width.
    assign line_err  = h_fall & ~first_line_reg & (h_reg != H_LAST);
    assign width_err = h_rise & ((h_reg + 10'd1) != H_LOW);
    assign frame_err = align & ~first_frame_reg & (v_reg != V_LAST);
    assign chk_err   = line_err | width_err | frame_err;
    assign timeout   = ~h_fall & (h_reg == (CNT_MAX - 10'd1));
    assign frame_ok  = ~(frame_bad_reg | chk_err);

    always_comb begin
        h_next      = h_reg;
        v_next      = v_reg;
        v_pend_next = v_pend_reg | v_fall;
        if (h_fall) begin
            h_next = '0;
            if (align) begin
                v_next      = '0;
                v_pend_next = 1'b0;
            end else if (v_reg != CNT_MAX) begin
                v_next = v_reg + 10'd1;
            end
        end else if (h_reg != CNT_MAX) begin
            h_next = h_reg + 10'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        if (timeout) begin
            state_next = SEARCH;
        end else begin
            case (state_reg)
                SEARCH: if (align) state_next = VERIFY;
                VERIFY: begin
                    if (align) begin
                        good_next = frame_ok ? good_reg + 4'd1 : 4'd0;
                        if (frame_ok && (good_reg + 4'd1 == LOCK_N)) state_next = LOCKED;
                    end
                end
                LOCKED: if (chk_err) state_next = SEARCH;
                default: state_next = SEARCH;
            endcase
        end
        if (state_next == SEARCH) good_next = '0;
    end

    // Entering SEARCH re-arms the exemptions for the first line and first frame alignment.
    assign enter_search     = (state_next == SEARCH) & ((state_reg != SEARCH) | timeout);
    assign first_line_next  = enter_search | (first_line_reg & ~h_fall);
    assign first_frame_next = enter_search | (first_frame_reg & ~align);
    assign frame_bad_next   = align ? 1'b0 : (frame_bad_reg | chk_err);

    assign de_next = (state_next == LOCKED) &&
                     (h_next >= HA_START) && (h_next <= HA_END) &&
                     (v_next >= VA_START) && (v_next <= VA_END);
    assign y_diff  = v_next - VA_START;
    assign x_next  = de_next ? (h_next - HA_START) : '0;
    assign y_next  = de_next ? y_diff[8:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= SEARCH;
            good_reg        <= '0;
            h_reg           <= '0;
            v_reg           <= '0;
            v_pend_reg      <= 1'b0;
            frame_bad_reg   <= 1'b0;
            first_line_reg  <= 1'b1;
            first_frame_reg <= 1'b1;
            de_reg          <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            fs_reg          <= 1'b0;
            err_reg         <= 1'b0;
        end else if (pix_ce) begin
            state_reg       <= state_next;
            good_reg        <= good_next;
            h_reg           <= h_next;
            v_reg           <= v_next;
            v_pend_reg      <= v_pend_next;
            frame_bad_reg   <= frame_bad_next;
            first_line_reg  <= first_line_next;
            first_frame_reg <= first_frame_next;
            de_reg          <= de_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            fs_reg          <= align;
            err_reg         <= chk_err | timeout;
        end
    end

    assign h_pos       = h_reg;
    assign v_pos       = v_reg;
    assign locked      = (state_reg == LOCKED);
    assign de          = de_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign frame_start = fs_reg;
    assign sync_err    = err_reg;

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Randomized bench for vga_sync_tracker on a shrunken 32x10 raster, checked every pixel
// tick against a behavioural model of the tracking rules plus scenario-level expectations.
module tb_vga_sync_tracker;
    localparam int HT    = 32;
    localparam int HS    = 4;
    localparam int HA0   = 8;
    localparam int HA1   = 29;
    localparam int VT    = 10;
    localparam int VA0   = 2;
    localparam int VA1   = 8;
    localparam int VSW   = 2;
    localparam int LF    = 2;
    localparam int FRAME = HT * VT;
    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pix_ce = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [9:0] h_pos, v_pos, x;
    logic [8:0] y;
    logic       locked, de, frame_start, sync_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: last three input samples, counters, lock bookkeeping.
    logic hq[3];
    logic vq[3];
    int   mh, mv, low_len, mode, good;
    bit   pend, skip_line, skip_frame, fbad, e_fs, e_err;

    // Scenario observations.
    int fs_count, err_count, lock_at;
    bit prev_locked, drop_ok;

    always #5 clk = ~clk;

    vga_sync_tracker #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
        .V_TOTAL(VT), .V_ACT_START(VA0), .V_ACT_END(VA1), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .h_pos(h_pos), .v_pos(v_pos), .locked(locked), .de(de),
        .x(x), .y(y), .frame_start(frame_start), .sync_err(sync_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [42:0] dut_out();
        return {h_pos, v_pos, locked, de, x, y, frame_start, sync_err};
    endfunction

    function automatic logic [42:0] model_out();
        logic       lk, d;
        logic [9:0] ex;
        logic [8:0] ey;
        lk = (mode == M_LOCKED);
        d  = lk && mh >= HA0 && mh <= HA1 && mv >= VA0 && mv <= VA1;
        ex = d ? 10'(mh - HA0) : 10'd0;
        ey = d ? 9'(mv - VA0) : 9'd0;
        return {10'(mh), 10'(mv), lk, d, ex, ey, e_fs, e_err};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hq[i] = 1'b1;
            vq[i] = 1'b1;
        end
        mh = 0; mv = 0; low_len = 0; mode = M_SEARCH; good = 0;
        pend = 0; skip_line = 1; skip_frame = 1; fbad = 0; e_fs = 0; e_err = 0;
    endtask

    task automatic model_step(input logic hs, input logic vs);
        logic hc, hp, vc, vp;
        bit   fall, rise, vfall, tmo, err, enter;
        hp = hq[0]; hc = hq[1]; vp = vq[0]; vc = vq[1];
        hq[0] = hq[1]; hq[1] = hq[2]; hq[2] = hs;
        vq[0] = vq[1]; vq[1] = vq[2]; vq[2] = vs;
        fall = hp && !hc; rise = !hp && hc; vfall = vp && !vc;
        err = 0; tmo = 0; enter = 0; e_fs = 0;
        if (fall) begin
            if (!skip_line && mh != HT - 1) err = 1;
            skip_line = 0;
            low_len = 1;
            if (pend || vfall) begin
                e_fs = 1;
                if (!skip_frame && mv != VT - 1) err = 1;
                skip_frame = 0; pend = 0; mv = 0;
            end else if (mv < 1023) begin
                mv++;
            end
            mh = 0;
        end else begin
            if (rise && low_len != HS) err = 1;
            if (!hc) low_len++;
            if (vfall) pend = 1;
            if (mh == 1022) tmo = 1;
            if (mh < 1023) mh++;
        end
        if (tmo) begin
            mode = M_SEARCH; enter = 1;
        end else if (mode == M_SEARCH) begin
            if (e_fs) mode = M_VERIFY;
        end else if (mode == M_VERIFY) begin
            if (e_fs) begin
                good = (fbad || err) ? 0 : good + 1;
                if (good == LF) mode = M_LOCKED;
            end
        end else if (err) begin
            mode = M_SEARCH; enter = 1;
        end
        if (mode == M_SEARCH) good = 0;
        if (enter) begin
            skip_line = 1; skip_frame = 1;
        end
        fbad  = e_fs ? 0 : (fbad || err);
        e_err = err || tmo;
    endtask

    task automatic clear_obs();
        fs_count = 0; err_count = 0; lock_at = -1; drop_ok = 0;
    endtask

    // One pixel tick: pix_ce idles low for a few clocks, then pulses for one clock.
    task automatic tick(input logic hs, input logic vs);
        int gap;
        gap = 3;
        if ($urandom_range(0, 9) == 0) gap += $urandom_range(1, 4);
        hsync_in = hs;
        vsync_in = vs;
        repeat (gap) @(negedge clk);
        pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        model_step(hs, vs);
        check_val("outputs", 64'(dut_out()), 64'(model_out()));
        if (locked && h_pos == HA0 && v_pos == VA0)
            check_val("de_first_pixel", 64'({de, x, y}), 64'({1'b1, 10'd0, 9'd0}));
        if (locked && h_pos == HA1 + 1)
            check_val("de_past_end", 64'({de, x}), 64'(0));
        if (locked && !prev_locked && frame_start) lock_at = fs_count;
        if (sync_err && prev_locked) drop_ok = !locked;
        if (sync_err) err_count++;
        if (frame_start) fs_count++;
        prev_locked = locked;
    endtask

    task automatic send_line(input int len, input int low_w, input logic vs);
        for (int h = 0; h < len; h++) tick(h >= low_w, vs);
    endtask

    task automatic send_frame(input int short_line, input int narrow_line);
        for (int l = 0; l < VT; l++)
            send_line(l == short_line ? HT - 1 : HT, l == narrow_line ? HS - 1 : HS, l >= VSW);
    endtask

    task automatic send_span(input int first, input int last);
        for (int i = first; i <= last; i++) tick((i % HT) >= HS, (i / HT) >= VSW);
    endtask

    initial begin
        int r, k, len, w;
        model_reset();
        clear_obs();
        prev_locked = 0;
        #1 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        check_val("reset_state", 64'(dut_out()), 64'(0));
        rst_n = 1'b1;
        repeat ($urandom_range(5, 40)) tick(1'b1, 1'b1);

        clear_obs();
        repeat (4) send_frame(-1, -1);
        check_val("nominal_lock_frame", 64'(lock_at), 64'(2));
        check_val("nominal_no_err", 64'(err_count), 64'(0));
        check_val("nominal_locked", 64'(locked), 64'(1));

        clear_obs();
        r = $urandom_range(0, VT - 2);
        send_frame(r, -1);
        repeat (3) send_frame(-1, -1);
        check_val("short_err_count", 64'(err_count), 64'(1));
        check_val("short_drop_same_tick", 64'(drop_ok), 64'(1));
        check_val("short_relock_frame", 64'(lock_at), 64'(3));

        clear_obs();
        r = $urandom_range(0, VT - 1);
        send_frame(-1, r);
        repeat (3) send_frame(-1, -1);
        check_val("narrow_err_count", 64'(err_count), 64'(1));
        check_val("narrow_drop_same_tick", 64'(drop_ok), 64'(1));
        check_val("narrow_relock_frame", 64'(lock_at), 64'(3));

        clear_obs();
        repeat (1100) tick(1'b1, 1'b1);
        check_val("timeout_hpos", 64'(h_pos), 64'(1023));
        check_val("timeout_locked", 64'(locked), 64'(0));
        check_val("timeout_err_count", 64'(err_count), 64'(1));
        check_val("timeout_drop", 64'(drop_ok), 64'(1));
        clear_obs();
        repeat (3) send_frame(-1, -1);
        check_val("timeout_relock_frame", 64'(lock_at), 64'(2));

        k = $urandom_range(VSW * HT + 1, FRAME - HT);
        send_span(0, k - 1);
        check_val("pre_reset_locked", 64'(locked), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset", 64'(dut_out()), 64'(0));
        model_reset();
        prev_locked = 0;
        clear_obs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_span(k, FRAME - 1);
        repeat (3) send_frame(-1, -1);
        check_val("reset_relock_frame", 64'(lock_at), 64'(2));

        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < VT; l++) begin
                len = HT;
                w   = HS;
                if ($urandom_range(0, 7) == 0) len = HT - 1 + 2 * $urandom_range(0, 1);
                if ($urandom_range(0, 7) == 0) w = HS - 1 + 2 * $urandom_range(0, 1);
                send_line(len, w, l >= VSW);
            end
        end
        send_frame(-1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_tracker.md
# vga_sync_tracker

Recovers pixel position from an incoming 640x480@60 VGA sync stream (hsync/vsync, active-low pulses, 800x525 totals). It checks that the stream's timing is correct and reports lock. It is the receive-side counterpart of the display timing generator: it sits on any board or overlay path that sees only the sync wires. It regenerates h/v counters, display-enable and active-area coordinates for downstream pixel logic.

## Interface
- H_TOTAL, 800, pixel ticks per line
- H_SYNC, 96, hsync low width in ticks
- H_ACT_START, 144, first active pixel index
- H_ACT_END, 783, last active pixel index
- V_TOTAL, 525, lines per frame
- V_ACT_START, 35, first active line index
- V_ACT_END, 514, last active line index
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel-tick enable, one clk wide, every 4th clk; all state advances only when pix_ce=1
- hsync_in  in  1  incoming horizontal sync, active low, asynchronous to clk
- vsync_in  in  1  incoming vertical sync, active low, asynchronous to clk
- h_pos  out  10  recovered pixel index within line
- v_pos  out  10  recovered line index within frame
- locked  out  1  timing verified and stable
- de  out  1  display enable
- x  out  10  active column (h_pos-H_ACT_START) when de, else 0
- y  out  9  active row (v_pos-V_ACT_START) when de, else 0
- frame_start  out  1  one-tick pulse at the hsync fall that aligns v_pos to 0
- sync_err  out  1  one-tick pulse on any timing violation

## Operation
- Input stage: hsync_in and vsync_in each pass through a 2-flop synchronizer that advances on pix_ce. A third flop holds the previous value for edge detection. All these flops reset to 1, so no false edge occurs at reset.
- hsync fall (prev=1, cur=0):
  - h_pos<=0.
  - Line check: previous h_pos must equal H_TOTAL-1, except on the first fall after entering SEARCH.
- hsync rise: h_pos must equal H_SYNC, i.e. low for indices 0..H_SYNC-1.
- Other ticks: h_pos increments and saturates at 1023. Reaching 1023 is a timeout error and forces SEARCH.
- vsync fall: sets v_pending.
- At each hsync fall:
  - If v_pending is set, or a vsync fall occurs on the same tick: v_pos<=0, clear v_pending, pulse frame_start. Frame check: previous v_pos must equal V_TOTAL-1, except on the first alignment.
  - Otherwise v_pos increments, saturating at 1023.
- A failed line, width or frame check sets frame_bad and pulses sync_err.
- Lock FSM, evaluated on pix_ce:
  - SEARCH: locked=0, good_cnt=0. Go to VERIFY on the first frame_start.
  - VERIFY: at each frame_start, if frame_bad=0 then good_cnt++, else good_cnt=0. Clear frame_bad at every frame_start. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked=1. Any sync_err or timeout goes to SEARCH, and locked drops on that same tick.
- de=1 only when locked=1, H_ACT_START<=h_pos<=H_ACT_END and V_ACT_START<=v_pos<=V_ACT_END.

## Timing
- All outputs are registered and update only on clk edges where pix_ce=1.
- Input-to-output latency is 3 pixel ticks: 2 synchronizer stages plus the output register. h_pos reads 0 on the third pix_ce after hsync_in is first low at a pix_ce sample.
- frame_start and sync_err are high for exactly one pix_ce period, from one enabled edge to the next.
- Reset values: h_pos=0, v_pos=0, locked=0, de=0, x=0, y=0, frame_start=0, sync_err=0, FSM=SEARCH, v_pending=0, frame_bad=0.
- Reset asserted mid-frame clears everything immediately. Re-lock requires a fresh frame_start plus LOCK_FRAMES good frames.
- When hsync fall and vsync fall coincide, as in the nominal stream, the vertical alignment applies on that same tick.
- pix_ce held low freezes all state.

## Test plan
- Nominal 800x525 stream, syncs low at h=0..95 and v=0..1, LOCK_FRAMES=2 -> frame_start at frame 0 start; locked rises at the frame 2 frame_start; sync_err is never asserted.
- Locked, then one line shortened to 799 ticks -> sync_err pulse at that hsync fall, locked=0 on the same tick, re-lock after 2 more good frames.
- Locked, hsync low width 95 -> sync_err at the hsync rise, FSM returns to SEARCH.
- Locked, sample pixel at h_pos=144, v_pos=35 -> de=1, x=0, y=0; at h_pos=784 -> de=0, x=0.
- hsync stuck high for 1100 ticks -> h_pos saturates at 1023, timeout forces SEARCH, locked=0.
- rst_n pulsed low mid-frame while locked -> all outputs 0 asynchronously; locked returns only after frame_start plus 2 good frames.
